// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the seven-segment scan driver
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Wide enough for the largest digit count; the driver slices what it needs.
  localparam logic [7:0] AN_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low segment pattern
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode seven-segment driver
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    scan_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] snap_val;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    load_pend;
  logic                    tick_q;

  logic                    tick;
  logic                    load;
  logic [3:0]              nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    hi_zero;

  assign tick   = (cnt == CNT_LAST);
  assign load   = (tick && (idx == IDX_LAST)) || load_pend;
  assign nibble = snap_val[{idx, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // Walk down from the top digit; a digit is blank while everything above it is zero.
  always_comb begin
    blank_mask = '0;
    hi_zero    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      hi_zero       = hi_zero && (snap_val[4*i +: 4] == 4'h0);
      blank_mask[i] = blank_lz && hi_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      snap_val  <= '0;
      snap_dp   <= '0;
      load_pend <= 1'b1;
      tick_q    <= 1'b0;
      an        <= AN_OFF[NUM_DIGITS-1:0];
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
      scan_tick <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (load) begin
        snap_val  <= value;
        snap_dp   <= dp_in;
        load_pend <= 1'b0;
      end
      // Two stages so the pulse lines up with the anode change, which lags idx by one.
      tick_q    <= tick;
      scan_tick <= tick_q;
      an        <= ~(NUM_DIGITS'(1) << idx);
      if (blank_mask[idx]) begin
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else begin
        seg <= dec_seg;
        dp  <= ~snap_dp[idx];
      end
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the board's common-anode seven-segment display. It takes a hex value from the datapath, shows one nibble per digit, and cycles through the digits at a refresh rate set by an internal clock-enable prescaler. It runs entirely on the board clock and generates no derived clocks. It sits downstream of the clock-division logic, at the display end of the design.

## Interface
- `REFRESH_DIV`, default 100000: board-clock cycles per digit slot. Legal range is ≥ 2.
- `NUM_DIGITS`, default 4: number of multiplexed digits. Legal range is 1..8.
- `clk`, input, 1: board clock. It is the only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `value`, input, 4*NUM_DIGITS: hex value to display. Nibble i drives digit i; digit 0 is rightmost.
- `dp_in`, input, NUM_DIGITS: decimal point request per digit, active-high.
- `blank_lz`, input, 1: when high, leading zeros are blanked.
- `an`, output, NUM_DIGITS: digit anode enables, active-low.
- `seg`, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp`, output, 1: decimal point, active-low.
- `scan_tick`, output, 1: one-cycle pulse at every digit advance.

## Operation
**Prescaler**
- `cnt` counts 0..REFRESH_DIV-1 and wraps to 0.
- `tick` is asserted when `cnt` == REFRESH_DIV-1.
- Counter width is $clog2(REFRESH_DIV).

**Digit index**
- `idx` counts 0..NUM_DIGITS-1.
- It advances on `tick` and wraps from NUM_DIGITS-1 to 0.
- With NUM_DIGITS = 1, `idx` stays at 0.

**Snapshot**
- `snap_val` and `snap_dp` hold a frame-stable copy of `value` and `dp_in`, so the display never tears mid-frame.
- Load conditions: `tick` with `idx` == NUM_DIGITS-1, or `load_pend`.
- `load_pend` is set by reset and cleared by the first load.
- Input changes at any other time are not visible until the next frame boundary.

**Leading-zero blanking**
- Digit i (i ≥ 1) is blank when `blank_lz`=1 and snapshot nibbles i..NUM_DIGITS-1 are all zero.
- Digit 0 is never blanked, so value 0 shows a single "0".
- A blank digit outputs `seg` = 7'h7F and `dp` = 1. Its anode is still driven low.
- `blank_lz` is sampled live, not snapshotted.

**Output decode**
- `an` = ~(1 << idx). `seg` = hex decode of snapshot nibble `idx`. `dp` = ~`snap_dp[idx]`.
- All outputs are registered.
- Hex decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- **Reset values:** `cnt`=0, `idx`=0, `snap_val`=0, `snap_dp`=0, `load_pend`=1, `an`=all ones, `seg`=7'h7F, `dp`=1, `scan_tick`=0.
- **First clock after reset release:**
  - `snap` loads the inputs.
  - Outputs register digit 0 of the old snapshot, i.e. "0" with all anodes off except `an[0]` low.
- **Second clock after reset release:** outputs show digit 0 of the loaded value.
- **Latency:** one clock from `idx`/`snap` to `an`/`seg`/`dp`.
- **scan_tick:** registered copy of `tick`. It is high for exactly one cycle, in the same cycle the new `an` appears.
- **Digit period:** exactly REFRESH_DIV cycles. Frame period is REFRESH_DIV*NUM_DIGITS cycles.
- **Reset mid-scan:** returns every register to its reset value on the next edge. No partial-digit carry-over.
- **Input change coinciding with a frame-boundary tick:** the new value is captured and shown starting at digit 0 of the new frame.

## Structure
- Shared package `seg7_pkg` holds:
  - the 16-entry hex-to-segment constant table;
  - `SEG_BLANK` = 7'h7F;
  - `AN_OFF` for the reset/off anode pattern.
- Sub-module `hex_to_seg7` is purely combinational: 4-bit nibble in, 7-bit active-low pattern out. It is instantiated once, muxed by `idx`.
- The top module holds the prescaler, index, snapshot and output registers.

## Test plan
Bench parameters are REFRESH_DIV=4 and NUM_DIGITS=4.
- **Reset:** hold `rst` 3 cycles with `value`=16'h1234 → `an`=4'b1111, `seg`=7'h7F, `dp`=1, `scan_tick`=0 during reset.
- **Scan order:** `value`=16'h1234, `dp_in`=0, `blank_lz`=0.
  - `an` steps 1110→1101→1011→0111→1110, each held for 4 cycles.
  - `seg` = 4,3,2,1 patterns: 0011001, 0110000, 0100100, 1111001.
  - `scan_tick` pulses every 4 cycles.
- **Snapshot:** change `value` from 16'h1234 to 16'hABCD while `idx`=1 → digits 1..3 still show 3,2,1. The next frame shows D,C,b,A.
- **Blanking:** `value`=16'h0050, `blank_lz`=1 → digits 3 and 2 show `seg`=7'h7F. Digit 1 shows 5 (0010010), digit 0 shows 0 (1000000). With `value`=0, only digit 0 shows "0".
- **Decimal point:** `dp_in`=4'b0100 → `dp`=0 only while `an`=4'b1011.
- **Mid-scan reset:** assert `rst` 1 cycle while `idx`=2 → next cycle `an`=1111, `idx`=0. The scan restarts from digit 0 with a fresh snapshot.
